// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile writeback path.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback sources and RegisterFile write port bundle.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);

    logic              s0_valid;
    logic              s0_ready;
    logic [ADDR_W-1:0] s0_rw;
    logic [DATA_W-1:0] s0_data;

    logic              s1_valid;
    logic              s1_ready;
    logic [ADDR_W-1:0] s1_rw;
    logic [DATA_W-1:0] s1_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_rw;
    logic [DATA_W-1:0] rf_busw;

    modport master (
        output s0_valid, s0_rw, s0_data,
        output s1_valid, s1_rw, s1_data,
        input  s0_ready, s1_ready,
        input  rf_we, rf_rw, rf_busw
    );

    modport slave (
        input  s0_valid, s0_rw, s0_data,
        input  s1_valid, s1_rw, s1_data,
        output s0_ready, s1_ready,
        output rf_we, rf_rw, rf_busw
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_q remembers the most recent winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;
    logic both;
    logic only0;
    logic only1;

    assign both  = (req == 2'b11);
    assign only0 = (req == 2'b01);
    assign only1 = (req == 2'b10);

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            both:    grant = last_q ? 2'b01 : 2'b10;
            only0:   grant = 2'b01;
            only1:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[1];
        end
    end

    // Reset to 1 so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load/MDU writebacks onto the single regfile write port.
module regfile_wb_arbiter #(
    parameter int DATA_W      = regfile_pkg::DATA_W,
    parameter int ADDR_W      = regfile_pkg::ADDR_W,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_wb_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    import regfile_pkg::*;

    localparam bit ZERO_EN = (ZERO_REG_EN != 0);

    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } req_t;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              drop;
    logic              both;
    req_t              sel;

    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] rw_q;
    logic [ADDR_W-1:0] rw_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  cc_q;
    logic [CNT_W-1:0]  cc_d;
    logic [CNT_W-1:0]  dc_q;
    logic [CNT_W-1:0]  dc_d;

    assign req  = {bus.s1_valid, bus.s0_valid};
    assign both = &req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign accept       = |grant;
    assign bus.s0_ready = grant[0];
    assign bus.s1_ready = grant[1];

    always_comb begin
        sel.rw   = bus.s0_rw;
        sel.data = bus.s0_data;
        if (grant[1]) begin
            sel.rw   = bus.s1_rw;
            sel.data = bus.s1_data;
        end
    end

    // r0 writes are still accepted so the source never stalls on them.
    assign drop = accept && ZERO_EN && (sel.rw == ADDR_W'(ZERO_REG));

    always_comb begin
        we_d   = accept && !drop;
        rw_d   = rw_q;
        data_d = data_q;
        if (we_d) begin
            rw_d   = sel.rw;
            data_d = sel.data;
        end
    end

    always_comb begin
        cc_d = cc_q;
        dc_d = dc_q;
        if (both && !(&cc_q)) begin
            cc_d = cc_q + CNT_W'(1);
        end
        if (drop && !(&dc_q)) begin
            dc_d = dc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rw_q   <= '0;
            data_q <= '0;
            cc_q   <= '0;
            dc_q   <= '0;
        end else begin
            we_q   <= we_d;
            rw_q   <= rw_d;
            data_q <= data_d;
            cc_q   <= cc_d;
            dc_q   <= dc_d;
        end
    end

    assign bus.rf_we   = we_q;
    assign bus.rf_rw   = rw_q;
    assign bus.rf_busw = data_q;

    assign conflict_cnt = cc_q;
    assign drop_cnt     = dc_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Random and directed checks of regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [4:0]  rw0 = '0;
    logic [4:0]  rw1 = '0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;

    assign ifa.s0_valid = v0;
    assign ifa.s0_rw    = rw0;
    assign ifa.s0_data  = d0;
    assign ifa.s1_valid = v1;
    assign ifa.s1_rw    = rw1;
    assign ifa.s1_data  = d1;
    assign ifb.s0_valid = v0;
    assign ifb.s0_rw    = rw0;
    assign ifb.s0_data  = d0;
    assign ifb.s1_valid = v1;
    assign ifb.s1_rw    = rw1;
    assign ifb.s1_data  = d1;
    assign ifc.s0_valid = v0;
    assign ifc.s0_rw    = rw0;
    assign ifc.s0_data  = d0;
    assign ifc.s1_valid = v1;
    assign ifc.s1_rw    = rw1;
    assign ifc.s1_data  = d1;

    logic [15:0] cc_a;
    logic [15:0] dc_a;
    logic [15:0] cc_b;
    logic [15:0] dc_b;
    logic [3:0]  cc_c;
    logic [3:0]  dc_c;

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG_EN(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .conflict_cnt(cc_a), .drop_cnt(dc_a)
    );

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG_EN(0), .CNT_W(16)
    ) dut_nz (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
        .conflict_cnt(cc_b), .drop_cnt(dc_b)
    );

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG_EN(1), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
        .conflict_cnt(cc_c), .drop_cnt(dc_c)
    );

    // RegisterFile fed by the main DUT.
    logic [31:0] rfm [32] = '{default: 32'h0};

    always @(posedge clk) begin
        if (ifa.rf_we) rfm[ifa.rf_rw] <= ifa.rf_busw;
    end

    a_s0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (v0 && !ifa.s0_ready) |=> (v0 && $stable(rw0) && $stable(d0)))
        else $error("FAIL s0_hold protocol");
    a_s1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (v1 && !ifa.s1_ready) |=> (v1 && $stable(rw1) && $stable(d1)))
        else $error("FAIL s1_hold protocol");

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    wb_req_t     q0[$];
    wb_req_t     q1[$];
    bit          gaps = 1'b0;
    bit          acc0 = 1'b0;
    bit          acc1 = 1'b0;
    int          w0 = 0;
    int          w1 = 0;

    bit          lg = 1'b1;
    bit          e_we = 1'b0;
    logic [4:0]  e_rw = '0;
    logic [31:0] e_d = '0;
    bit          n_we = 1'b0;
    logic [4:0]  n_rw = '0;
    logic [31:0] n_d = '0;
    int          cc = 0;
    int          cs = 0;
    int          dc = 0;
    int          ds = 0;
    logic [31:0] exp_rf [32] = '{default: 32'h0};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v < m) ? v + 1 : v;
    endfunction

    function automatic wb_req_t mk(input logic [4:0] rw, input logic [31:0] d);
        wb_req_t r;
        r.rw   = rw;
        r.data = d;
        return r;
    endfunction

    task automatic cycle();
        bit      g0;
        bit      g1;
        wb_req_t r;
        @(negedge clk);
        g0 = v0 && (!v1 || lg);
        g1 = v1 && (!v0 || !lg);
        chk("s0_ready", ifa.s0_ready, g0);
        chk("s1_ready", ifa.s1_ready, g1);
        chk("rf_we", ifa.rf_we, e_we);
        chk("rf_rw", ifa.rf_rw, e_rw);
        chk("rf_busw", ifa.rf_busw, e_d);
        chk("nz_rf_we", ifb.rf_we, n_we);
        chk("nz_rf_rw", ifb.rf_rw, n_rw);
        chk("nz_rf_busw", ifb.rf_busw, n_d);
        chk("conflict_cnt", cc_a, cc);
        chk("drop_cnt", dc_a, dc);
        chk("nz_drop_cnt", dc_b, 0);
        chk("sat_conflict_cnt", cc_c, cs);
        chk("sat_drop_cnt", dc_c, ds);
        if (e_we) exp_rf[e_rw] = e_d;
        acc0 = v0 && ifa.s0_ready;
        acc1 = v1 && ifa.s1_ready;
        w0 = (v0 && !acc0) ? w0 + 1 : 0;
        w1 = (v1 && !acc1) ? w1 + 1 : 0;
        chk("s0_wait_bound", w0 <= 1, 1);
        chk("s1_wait_bound", w1 <= 1, 1);
        if (v0 && v1) begin
            cc = sat(cc, 65535);
            cs = sat(cs, 15);
        end
        e_we = 1'b0;
        n_we = 1'b0;
        if (g0 || g1) begin
            r    = g1 ? mk(rw1, d1) : mk(rw0, d0);
            lg   = g1;
            n_we = 1'b1;
            n_rw = r.rw;
            n_d  = r.data;
            if (r.rw == 5'd0) begin
                dc = sat(dc, 65535);
                ds = sat(ds, 15);
            end else begin
                e_we = 1'b1;
                e_rw = r.rw;
                e_d  = r.data;
            end
        end
        @(posedge clk);
        #1;
        if (!v0 || acc0) begin
            v0 = 1'b0;
            if (q0.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
                r = q0.pop_front();
                v0 = 1'b1; rw0 = r.rw; d0 = r.data;
            end
        end
        if (!v1 || acc1) begin
            v1 = 1'b0;
            if (q1.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
                r = q1.pop_front();
                v1 = 1'b1; rw1 = r.rw; d1 = r.data;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || v0 || v1) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 300, 1);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rf_we", ifa.rf_we, 0);
        chk("rst_rf_rw", ifa.rf_rw, 0);
        chk("rst_rf_busw", ifa.rf_busw, 0);
        chk("rst_nz_rf_we", ifb.rf_we, 0);
        chk("rst_conflict_cnt", cc_a, 0);
        chk("rst_drop_cnt", dc_a, 0);
        v0 = 1'b0; v1 = 1'b0;
        q0.delete(); q1.delete();
        acc0 = 1'b0; acc1 = 1'b0; w0 = 0; w1 = 0;
        lg = 1'b1;
        e_we = 1'b0; e_rw = '0; e_d = '0;
        n_we = 1'b0; n_rw = '0; n_d = '0;
        cc = 0; cs = 0; dc = 0; ds = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset in the middle of an s0 stream, then one clean write.
        for (int i = 0; i < 4; i++) q0.push_back(mk(5'(10 + i), $urandom));
        repeat (3) cycle();
        do_reset();
        q0.push_back(mk(5'd3, 32'hA5A5A5A5));
        drain();
        chk("reset_then_r3", rfm[3], 32'hA5A5A5A5);

        do_reset();
        for (int i = 1; i <= 8; i++) q1.push_back(mk(5'(i), 32'(100 + i)));
        drain();
        chk("single_src_conflict", cc_a, 0);
        chk("single_src_r8", rfm[8], 108);

        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back(mk(5'(16 + i), $urandom));
        for (int i = 0; i < 3; i++) q1.push_back(mk(5'(20 + i), $urandom));
        drain();
        chk("contention_conflict", cc_a, 6);

        do_reset();
        q0.push_back(mk(5'd5, 32'h1));
        q1.push_back(mk(5'd5, 32'h2));
        drain();
        chk("same_reg_r5", rfm[5], 32'h2);

        do_reset();
        q0.push_back(mk(5'd0, 32'hDEADBEEF));
        drain();
        chk("zero_drop_cnt", dc_a, 1);
        chk("zero_r0_untouched", rfm[0], 0);

        do_reset();
        for (int i = 0; i < 12; i++) q0.push_back(mk(5'(i), $urandom));
        for (int i = 0; i < 12; i++) q1.push_back(mk(5'(12 + i), $urandom));
        drain();
        chk("sat_conflict_hold", cc_c, 15);
        chk("wide_conflict", cc_a, 23);

        do_reset();
        gaps = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() < 2 && $urandom_range(1) == 1)
                q0.push_back(mk(5'($urandom_range(31)), $urandom));
            if (q1.size() < 2 && $urandom_range(1) == 1)
                q1.push_back(mk(5'($urandom_range(31)), $urandom));
            cycle();
        end
        drain();
        gaps = 1'b0;

        for (int i = 0; i < 32; i++) chk($sformatf("rf_r%0d", i), rfm[i], exp_rf[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
